edge_detect_multi: RTL and testbench

Multi-channel, parametrised edge detector for asynchronous or noisy level inputs such as pins, status lines and cross-domain flags. Each channel synchronises its input, applies a consecutive-sample glitch filter, and qualifies level transitions against a per-channel edge mode. It emits one-cycle event pulses, keeps per-channel sticky flags with software clear, and drives a single maskable interrupt. It sits between raw inputs and the control/register logic that consumes events.

---
 rtl/edge_detect_multi_if.sv | 23 ++
 rtl/edge_detect_multi.sv | 113 +++++++++++
 tb/tb_edge_detect_multi.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/edge_detect_multi_if.sv
// edge_detect_multi_if: raw channel inputs, per-channel controls and event outputs
interface edge_detect_multi_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0]   data_in;
  logic [2*WIDTH-1:0] mode;
  logic [WIDTH-1:0]   clr;
  logic [WIDTH-1:0]   irq_en;
  logic [WIDTH-1:0]   level_out;
  logic [WIDTH-1:0]   edge_out;
  logic [WIDTH-1:0]   flag_out;
  logic               irq;

  modport master (
    output data_in, mode, clr, irq_en,
    input  level_out, edge_out, flag_out, irq
  );

  modport slave (
    input  data_in, mode, clr, irq_en,
    output level_out, edge_out, flag_out, irq
  );
endinterface

// File: rtl/edge_detect_multi.sv
// edge_detect_multi: per-channel synchroniser, glitch filter, edge qualifier,
// sticky flags and a maskable interrupt.
module edge_detect_multi #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned REG_EVENT   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init_n,
  edge_detect_multi_if.slave bus
);

  localparam int unsigned      CNT_W   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync_s;
  logic [WIDTH-1:0]                  lvl_q;
  logic [WIDTH-1:0]                  take_c;
  logic [WIDTH-1:0]                  event_c;
  logic [WIDTH-1:0]                  flag_q;
  logic                              irq_q;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: stage 0 captures the raw input, last stage feeds the filter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else if (!init_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.data_in};
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic             lvl_r;

    // A take is the cycle the persistent disagreement finally moves the level
    assign take_c[i]  = (sync_s[i] != lvl_r) && (cnt_q == CNT_MAX);
    assign event_c[i] = take_c[i] &
                        ((sync_s[i] & bus.mode[2*i]) | (~sync_s[i] & bus.mode[2*i+1]));
    assign lvl_q[i]   = lvl_r;

    // Glitch filter: any agreeing sample restarts the count, counter never wraps
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        lvl_r <= 1'b0;
      end else if (!init_n) begin
        cnt_q <= '0;
        lvl_r <= 1'b0;
      end else if (sync_s[i] == lvl_r) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        lvl_r <= sync_s[i];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  if (REG_EVENT != 0) begin : g_reg_evt
    logic [WIDTH-1:0] edge_q;

    // Registered event pulse, aligned with the level_out change
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        edge_q <= '0;
      end else if (!init_n) begin
        edge_q <= '0;
      end else begin
        edge_q <= event_c;
      end
    end

    assign bus.edge_out = edge_q;
  end else begin : g_comb_evt
    assign bus.edge_out = event_c;
  end

  // Sticky flags: a new event wins over a coincident clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= '0;
    end else if (!init_n) begin
      flag_q <= '0;
    end else begin
      flag_q <= event_c | (flag_q & ~bus.clr);
    end
  end

  // Interrupt follows the registered flags one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else if (!init_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(flag_q & bus.irq_en);
    end
  end

  assign bus.level_out = lvl_q;
  assign bus.flag_out  = flag_q;
  assign bus.irq       = irq_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// tb_edge_detect_multi: table-driven vectors plus directed corner-case sequences
module tb_edge_detect_multi;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic init_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  edge_detect_multi_if #(.WIDTH(W)) bus1 ();
  edge_detect_multi_if #(.WIDTH(W)) bus2 ();

  edge_detect_multi #(
    .WIDTH(W), .SYNC_STAGES(2), .FILT_LEN(4), .REG_EVENT(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .init_n(init_n), .bus(bus1)
  );

  edge_detect_multi #(
    .WIDTH(W), .SYNC_STAGES(2), .FILT_LEN(1), .REG_EVENT(0)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .init_n(init_n), .bus(bus2)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         do_rst;
    logic [3:0] din;
    logic [7:0] mode;
    logic [3:0] clr;
    logic [3:0] ien;
    logic [3:0] lvl;
    logic [3:0] edg;
    logic [3:0] flg;
    logic       irq;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input bit rst, input logic [3:0] din, input logic [7:0] md,
                              input logic [3:0] cl, input logic [3:0] ie,
                              input logic [3:0] lv, input logic [3:0] ed,
                              input logic [3:0] fl, input logic iq);
    vec_t v;
    v.do_rst = rst;
    v.din    = din;
    v.mode   = md;
    v.clr    = cl;
    v.ien    = ie;
    v.lvl    = lv;
    v.edg    = ed;
    v.flg    = fl;
    v.irq    = iq;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check1(input string tag, input logic [3:0] lv, input logic [3:0] ed,
                        input logic [3:0] fl, input logic iq);
    chk({tag, ".lvl"},  bus1.level_out, lv);
    chk({tag, ".edge"}, bus1.edge_out,  ed);
    chk({tag, ".flag"}, bus1.flag_out,  fl);
    chk({tag, ".irq"},  4'(bus1.irq),   4'(iq));
  endtask

  task automatic drive1(input logic [3:0] din, input logic [7:0] md,
                        input logic [3:0] cl, input logic [3:0] ie);
    bus1.data_in = din;
    bus1.mode    = md;
    bus1.clr     = cl;
    bus1.irq_en  = ie;
  endtask

  // Reset both instances with idle inputs and confirm every output is low
  task automatic do_reset();
    drive1(4'h0, 8'hFF, 4'h0, 4'h0);
    bus2.data_in = 4'h0;
    bus2.mode    = 8'h00;
    bus2.clr     = 4'h0;
    bus2.irq_en  = 4'h0;
    init_n = 1'b1;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check1("rst", 4'h0, 4'h0, 4'h0, 1'b0);
    chk("rst.d2.lvl",  bus2.level_out, 4'h0);
    chk("rst.d2.edge", bus2.edge_out,  4'h0);
    chk("rst.d2.flag", bus2.flag_out,  4'h0);
    chk("rst.d2.irq",  4'(bus2.irq),   4'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    int nz_cycles;
    int all_cycles;

    rst_n  = 1'b0;
    init_n = 1'b1;

    // A: ch0 held high; ch1 3-cycle glitch then 4-cycle pulse (all modes both)
    add(1, 4'b0011, 8'hFF, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    repeat (2) add(0, 4'b0011, 8'hFF, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    repeat (2) add(0, 4'b0001, 8'hFF, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    add(0, 4'b0001, 8'hFF, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 1'b0);
    repeat (4) add(0, 4'b0001, 8'hFF, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 1'b1);
    repeat (4) add(0, 4'b0011, 8'hFF, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 1'b1);
    add(0, 4'b0001, 8'hFF, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 1'b1);
    add(0, 4'b0001, 8'hFF, 4'h0, 4'h1, 4'h3, 4'h2, 4'h3, 1'b1);
    repeat (3) add(0, 4'b0001, 8'hFF, 4'h0, 4'h1, 4'h3, 4'h0, 4'h3, 1'b1);
    add(0, 4'b0001, 8'hFF, 4'h0, 4'h1, 4'h1, 4'h2, 4'h3, 1'b1);
    repeat (2) add(0, 4'b0001, 8'hFF, 4'h0, 4'h1, 4'h1, 4'h0, 4'h3, 1'b1);

    // B: ch0 rise-only, rise then fall each held 10 cycles
    add(1, 4'b0001, 8'hFD, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    repeat (4) add(0, 4'b0001, 8'hFD, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    add(0, 4'b0001, 8'hFD, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 1'b0);
    repeat (4) add(0, 4'b0001, 8'hFD, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 1'b1);
    repeat (5) add(0, 4'b0000, 8'hFD, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 1'b1);
    repeat (5) add(0, 4'b0000, 8'hFD, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b1);

    // C: ch2 clear coincident with its event, then a later clear
    add(1, 4'b0100, 8'hFF, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0);
    repeat (4) add(0, 4'b0100, 8'hFF, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0);
    add(0, 4'b0100, 8'hFF, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 1'b0);
    repeat (2) add(0, 4'b0100, 8'hFF, 4'h0, 4'h4, 4'h4, 4'h0, 4'h4, 1'b1);
    add(0, 4'b0100, 8'hFF, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 1'b1);
    repeat (2) add(0, 4'b0100, 8'hFF, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 1'b0);

    for (int k = 0; k < vq.size(); k++) begin
      if (vq[k].do_rst) do_reset();
      drive1(vq[k].din, vq[k].mode, vq[k].clr, vq[k].ien);
      @(posedge clk);
      #1;
      check1($sformatf("v%0d", k), vq[k].lvl, vq[k].edg, vq[k].flg, vq[k].irq);
    end

    // D: unfiltered, combinational-event instance
    do_reset();
    bus2.mode    = 8'hFF;
    bus2.irq_en  = 4'h1;
    bus2.data_in = 4'h1;
    @(posedge clk); #1;
    chk("d.e0.edge", bus2.edge_out, 4'h0);
    @(posedge clk); #1;
    chk("d.e1.edge", bus2.edge_out,  4'h1);
    chk("d.e1.lvl",  bus2.level_out, 4'h0);
    chk("d.e1.flag", bus2.flag_out,  4'h0);
    @(posedge clk); #1;
    chk("d.e2.edge", bus2.edge_out,  4'h0);
    chk("d.e2.lvl",  bus2.level_out, 4'h1);
    chk("d.e2.flag", bus2.flag_out,  4'h1);
    chk("d.e2.irq",  4'(bus2.irq),   4'h0);
    @(posedge clk); #1;
    chk("d.e3.irq",  4'(bus2.irq),   4'h1);

    // E: all channels high, init mid-count, then asynchronous reset
    do_reset();
    drive1(4'hF, 8'hFF, 4'h0, 4'hF);
    repeat (5) @(posedge clk);
    #1 chk("e.e4.lvl", bus1.level_out, 4'h0);
    @(posedge clk); #1;
    check1("e.e5", 4'hF, 4'hF, 4'hF, 1'b0);
    @(posedge clk); #1;
    check1("e.e6", 4'hF, 4'h0, 4'hF, 1'b1);
    bus1.data_in = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    bus1.data_in = 4'hF;
    init_n = 1'b0;
    @(posedge clk); #1;
    check1("init", 4'h0, 4'h0, 4'h0, 1'b0);
    init_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("init.rel4.lvl", bus1.level_out, 4'h0);
    @(posedge clk); #1;
    check1("init.rel5", 4'hF, 4'hF, 4'hF, 1'b0);
    @(posedge clk); #1;
    check1("init.rel6", 4'hF, 4'h0, 4'hF, 1'b1);
    #2 rst_n = 1'b0;
    #1 check1("arst", 4'h0, 4'h0, 4'h0, 1'b0);
    #1 rst_n = 1'b1;
    nz_cycles  = 0;
    all_cycles = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus1.edge_out != 4'h0) nz_cycles++;
      if (bus1.edge_out == 4'hF) all_cycles++;
      if (c == 4) chk("arst.rel4.lvl", bus1.level_out, 4'h0);
      if (c == 5) chk("arst.rel5.lvl", bus1.level_out, 4'hF);
    end
    chk("arst.event_cycles", 4'(nz_cycles),  4'd1);
    chk("arst.all_ch_pulse", 4'(all_cycles), 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
